conv_window_feeder: RTL and testbench

- Transmit side of the binary conv-layer input interface.
- Serially loads a 9-bit binary 3x3 kernel over weight_en/weight, then converts a row-major 1-bit pixel stream into 3-row column taps plus a level-held conv_start.
- Holds two row line buffers whose length is selectable by layer (28 or 26 columns).
- Sits between the binarized feature-map source and the conv engine; it sequences one frame per kernel load.

---
 rtl/conv_pkg.sv | 17 +
 rtl/conv_window_feeder_if.sv | 29 ++
 rtl/line_buffer_bit.sv | 25 ++
 rtl/conv_window_feeder.sv | 128 ++++++++++++
 tb/tb_conv_window_feeder.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared constants and FSM encoding for the conv-layer input feeder.
package conv_pkg;
    localparam int W0  = 28;
    localparam int W1  = 26;
    localparam int KW  = 9;

    localparam int TOP = 2;
    localparam int MID = 1;
    localparam int BOT = 0;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_W    = 2'd1,
        STREAM    = 2'd2,
        WAIT_DONE = 2'd3
    } fsm_t;
endpackage

// File: rtl/conv_window_feeder_if.sv
// Pixel/kernel source and conv engine signals of the feeder, bundled.
interface conv_window_feeder_if;
    import conv_pkg::*;

    logic          state;
    logic [KW-1:0] kernel;
    logic          kernel_load;
    logic          din;
    logic          din_valid;
    logic          din_ready;
    logic          conv_done;
    logic          weight_en;
    logic          weight;
    logic [2:0]    taps;
    logic          taps_valid;
    logic          conv_start;
    logic          busy;
    logic          frame_done;

    modport master (
        output state, kernel, kernel_load, din, din_valid, conv_done,
        input  din_ready, weight_en, weight, taps, taps_valid, conv_start, busy, frame_done
    );

    modport slave (
        input  state, kernel, kernel_load, din, din_valid, conv_done,
        output din_ready, weight_en, weight, taps, taps_valid, conv_start, busy, frame_done
    );
endinterface

// File: rtl/line_buffer_bit.sv
// One-row 1-bit delay line; tap is the pixel exactly one row (N samples) old.
module line_buffer_bit
    import conv_pkg::*;
#(
    parameter int DEPTH = W0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_shift,
    input  logic i_short,
    input  logic i_din,
    output logic o_tap
);
    logic [DEPTH-1:0] r_sr;

    always_ff @(posedge clk) begin
        if (rst || i_clr)
            r_sr <= '0;
        else if (i_shift)
            r_sr <= {r_sr[DEPTH-2:0], i_din};
    end

    assign o_tap = i_short ? r_sr[W1-1] : r_sr[DEPTH-1];
endmodule

// File: rtl/conv_window_feeder.sv
// Loads a serial 3x3 binary kernel, then streams one frame as 3-row column taps.
module conv_window_feeder
    import conv_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    conv_window_feeder_if.slave  bus
);
    fsm_t          r_fsm;
    logic [3:0]    r_widx;
    logic [4:0]    r_col;
    logic [4:0]    r_row;
    logic          r_state;
    logic [KW-1:0] r_kernel;
    logic          r_weight_en;
    logic          r_weight;
    logic          r_din_ready;
    logic          r_conv_start;
    logic          r_frame_done;
    logic          r_taps_valid;
    logic [2:0]    r_taps;

    logic [4:0]    w_nm1;
    logic          w_accept;
    logic          w_lb_clr;
    logic          w_lb1_tap;
    logic          w_lb2_tap;

    assign w_nm1    = r_state ? 5'(W1-1) : 5'(W0-1);
    assign w_accept = (r_fsm == STREAM) && r_din_ready && bus.din_valid;
    assign w_lb_clr = (r_fsm == LOAD_W) && (r_widx == 4'd9);

    line_buffer_bit #(.DEPTH(W0)) u_lb1 (
        .clk(clk), .rst(rst), .i_clr(w_lb_clr), .i_shift(w_accept),
        .i_short(r_state), .i_din(bus.din), .o_tap(w_lb1_tap)
    );

    // LB2 is fed from the row-old tap, so its own tap is two rows old.
    line_buffer_bit #(.DEPTH(W0)) u_lb2 (
        .clk(clk), .rst(rst), .i_clr(w_lb_clr), .i_shift(w_accept),
        .i_short(r_state), .i_din(w_lb1_tap), .o_tap(w_lb2_tap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm        <= IDLE;
            r_widx       <= '0;
            r_col        <= '0;
            r_row        <= '0;
            r_state      <= 1'b0;
            r_kernel     <= '0;
            r_weight_en  <= 1'b0;
            r_weight     <= 1'b0;
            r_din_ready  <= 1'b0;
            r_conv_start <= 1'b0;
            r_frame_done <= 1'b0;
            r_taps_valid <= 1'b0;
            r_taps       <= '0;
        end else begin
            r_frame_done <= 1'b0;
            r_taps_valid <= 1'b0;
            case (r_fsm)
                IDLE: begin
                    if (bus.kernel_load) begin
                        r_kernel    <= bus.kernel;
                        r_state     <= bus.state;
                        r_widx      <= '0;
                        r_weight_en <= 1'b1;
                        r_weight    <= 1'b0;
                        r_fsm       <= LOAD_W;
                    end
                end
                LOAD_W: begin
                    // Bit widx goes out one cycle after its enable slot.
                    if (r_widx == 4'd9) begin
                        r_widx      <= '0;
                        r_weight    <= 1'b0;
                        r_weight_en <= 1'b0;
                        r_col       <= '0;
                        r_row       <= '0;
                        r_din_ready <= 1'b1;
                        r_fsm       <= STREAM;
                    end else begin
                        r_weight    <= r_kernel[r_widx];
                        r_weight_en <= (r_widx < 4'd8);
                        r_widx      <= r_widx + 4'd1;
                    end
                end
                STREAM: begin
                    if (w_accept) begin
                        r_taps       <= {w_lb2_tap, w_lb1_tap, bus.din};
                        r_taps_valid <= (r_row >= 5'd2);
                        r_conv_start <= 1'b1;
                        if (r_col == w_nm1) begin
                            r_col <= '0;
                            if (r_row == w_nm1) begin
                                r_row       <= '0;
                                r_din_ready <= 1'b0;
                                r_fsm       <= WAIT_DONE;
                            end else begin
                                r_row <= r_row + 5'd1;
                            end
                        end else begin
                            r_col <= r_col + 5'd1;
                        end
                    end
                end
                WAIT_DONE: begin
                    if (bus.conv_done) begin
                        r_conv_start <= 1'b0;
                        r_frame_done <= 1'b1;
                        r_fsm        <= IDLE;
                    end
                end
                default: r_fsm <= IDLE;
            endcase
        end
    end

    assign bus.din_ready  = r_din_ready;
    assign bus.weight_en  = r_weight_en;
    assign bus.weight     = r_weight;
    assign bus.taps       = r_taps;
    assign bus.taps_valid = r_taps_valid;
    assign bus.conv_start = r_conv_start;
    assign bus.frame_done = r_frame_done;
    assign bus.busy       = (r_fsm != IDLE);
endmodule

// File: tb/tb_conv_window_feeder.sv
// Randomized frames against a frame-array reference model; a monitor checks taps from a queue.
module tb_conv_window_feeder;
    import conv_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conv_window_feeder_if bus();

    conv_window_feeder dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int         total = 0;
    int         bad   = 0;
    int         n_valid = 0;
    logic [2:0] exp_q[$];
    bit         pix[0:27][0:27];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every valid tap must match the oldest expected column.
    always @(negedge clk) begin
        if (!rst && bus.taps_valid) begin
            n_valid++;
            if (exp_q.size() == 0) begin
                chk("taps_unexpected", 1, 0);
            end else begin
                logic [2:0] e;
                e = exp_q.pop_front();
                chk("taps", int'(bus.taps), int'(e));
            end
        end
    end

    initial begin
        #2_000_000;
        bad++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_busy"},       int'(bus.busy),       0);
        chk({pfx, "_din_ready"},  int'(bus.din_ready),  0);
        chk({pfx, "_weight_en"},  int'(bus.weight_en),  0);
        chk({pfx, "_weight"},     int'(bus.weight),     0);
        chk({pfx, "_taps"},       int'(bus.taps),       0);
        chk({pfx, "_taps_valid"}, int'(bus.taps_valid), 0);
        chk({pfx, "_conv_start"}, int'(bus.conv_start), 0);
        chk({pfx, "_frame_done"}, int'(bus.frame_done), 0);
    endtask

    task automatic fill(input int mode);
        for (int r = 0; r < 28; r++)
            for (int c = 0; c < 28; c++)
                case (mode)
                    0:       pix[r][c] = bit'((r + c) & 1);
                    1:       pix[r][c] = (r != 5);
                    default: pix[r][c] = bit'($urandom_range(1, 0));
                endcase
    endtask

    // Kernel load; din_valid is held high during LOAD_W and must be ignored.
    task automatic load(input logic [KW-1:0] k, input bit st);
        bus.kernel      = k;
        bus.state       = st;
        bus.kernel_load = 1'b1;
        bus.din         = 1'b1;
        bus.din_valid   = 1'b1;
        tick();
        bus.kernel_load = 1'b0;
        for (int t = 0; t < 10; t++) begin
            chk("weight_en", int'(bus.weight_en), (t <= 8) ? 1 : 0);
            chk("weight",    int'(bus.weight),    (t == 0) ? 0 : int'(k[t-1]));
            chk("load_busy", int'(bus.busy), 1);
            if (t == 9) bus.din_valid = 1'b0;
            tick();
        end
        chk("stream_din_ready",  int'(bus.din_ready),  1);
        chk("stream_conv_start", int'(bus.conv_start), 0);
    endtask

    task automatic run_frame(input bit st, input int abort_at, input bit inject_kl);
        int n;
        n = st ? W1 : W0;
        n_valid = 0;
        for (int k = 0; k < n * n; k++) begin
            int r, c, w;
            if (k == abort_at) begin
                bus.din_valid = 1'b0;
                rst = 1'b1;
                tick();
                chk_all_zero("abort");
                rst = 1'b0;
                exp_q.delete();
                for (int i = 0; i < 5; i++) begin
                    tick();
                    chk("abort_no_frame_done", int'(bus.frame_done), 0);
                    chk("abort_idle",          int'(bus.busy),       0);
                end
                return;
            end
            w = 0;
            while (!bus.din_ready && w < 20) begin
                tick();
                w++;
            end
            if (!bus.din_ready) begin
                chk("din_ready_timeout", int'(bus.din_ready), 1);
                bus.din_valid = 1'b0;
                return;
            end
            r = k / n;
            c = k % n;
            bus.din       = pix[r][c];
            bus.din_valid = 1'b1;
            bus.kernel_load = inject_kl && (k == 100);
            if (r >= 2)
                exp_q.push_back({pix[r-2][c], pix[r-1][c], pix[r][c]});
            tick();
            if (k == 0) chk("conv_start_rise", int'(bus.conv_start), 1);
            if (inject_kl && k == 100) begin
                chk("kl_ignored_busy",  int'(bus.busy),      1);
                chk("kl_ignored_ready", int'(bus.din_ready), 1);
                chk("kl_ignored_wen",   int'(bus.weight_en), 0);
            end
        end
        bus.din_valid   = 1'b0;
        bus.kernel_load = 1'b0;
        for (int i = 0; i < 50; i++) begin
            chk("wait_conv_start", int'(bus.conv_start), 1);
            chk("wait_din_ready",  int'(bus.din_ready),  0);
            chk("wait_frame_done", int'(bus.frame_done), 0);
            tick();
        end
        chk("valid_tap_count", n_valid, n * (n - 2));
        chk("scoreboard_empty", exp_q.size(), 0);
        // conv_done with a coincident kernel_load: the load must be dropped.
        bus.conv_done   = 1'b1;
        bus.kernel_load = 1'b1;
        tick();
        bus.conv_done   = 1'b0;
        bus.kernel_load = 1'b0;
        chk("done_frame_done", int'(bus.frame_done), 1);
        chk("done_conv_start", int'(bus.conv_start), 0);
        chk("done_busy",       int'(bus.busy),       0);
        tick();
        chk("done_pulse_end",  int'(bus.frame_done), 0);
        chk("done_no_reload",  int'(bus.busy),       0);
    endtask

    initial begin
        bus.state       = 1'b0;
        bus.kernel      = '0;
        bus.kernel_load = 1'b0;
        bus.din         = 1'b0;
        bus.din_valid   = 1'b0;
        bus.conv_done   = 1'b0;
        repeat (3) tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();
        // Stray conv_done in IDLE must do nothing.
        bus.conv_done = 1'b1;
        tick();
        bus.conv_done = 1'b0;
        chk("idle_conv_done_ignored", int'(bus.frame_done), 0);

        load(9'b1_0110_1001, 1'b0);
        fill(0);
        run_frame(1'b0, -1, 1'b1);

        load(KW'($urandom), 1'b1);
        fill(1);
        run_frame(1'b1, -1, 1'b0);

        load(KW'($urandom), 1'b0);
        fill(2);
        run_frame(1'b0, 300, 1'b0);

        load(KW'($urandom), 1'b0);
        fill(2);
        run_frame(1'b0, -1, 1'b0);

        load(KW'($urandom), 1'b1);
        fill(2);
        run_frame(1'b1, -1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
